// File: rtl/transmitter_framer.sv
// Serial frame transmitter: sends a control-code delimited frame carrying an
// index word and a payload word, MSB first, one bit per BIT_PERIOD clocks with a
// write strobe that rises mid-period.
module transmitter_framer #(
   parameter int unsigned PAYLOAD_WIDTH   = 16,
   parameter int unsigned REFERENCE_WIDTH = 16,
   parameter int unsigned BIT_PERIOD      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [PAYLOAD_WIDTH-1:0]   payload_i,
   input  logic [REFERENCE_WIDTH-1:0] index_i,
   output logic                       ready,
   output logic                       data_stream,
   output logic                       write,
   output logic                       done,
   output logic                       collision
);

   localparam logic [7:0] FRAME_HEADSTART = 8'hA5;
   localparam logic [7:0] FRAME_START     = 8'h5A;
   localparam logic [7:0] FRAME_END       = 8'h7E;

   localparam int unsigned PAY_BYTES = PAYLOAD_WIDTH / 8;
   localparam int unsigned REF_BYTES = REFERENCE_WIDTH / 8;
   localparam int unsigned MAX_BYTES = (PAY_BYTES > REF_BYTES) ? PAY_BYTES : REF_BYTES;
   localparam int unsigned BIT_W     = $clog2(BIT_PERIOD + 1);
   localparam int unsigned BYTE_W    = $clog2(MAX_BYTES + 1);

   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(BIT_PERIOD - 1);
   localparam logic [BIT_W-1:0]  BIT_HALF = BIT_W'(BIT_PERIOD / 2);
   localparam logic [BYTE_W-1:0] REF_LAST = BYTE_W'(REF_BYTES - 1);
   localparam logic [BYTE_W-1:0] PAY_LAST = BYTE_W'(PAY_BYTES - 1);

   typedef enum logic [2:0] {
      StIdle, StHeadstart, StIndex, StStart, StData, StEnd
   } state_e;

   state_e                     state_q, state_d;
   logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;   // clock within bit period
   logic [2:0]                 bit_idx_q, bit_idx_d;   // bit within byte, 0 = MSB
   logic [BYTE_W-1:0]          byte_cnt_q, byte_cnt_d; // byte within index/payload
   logic [PAYLOAD_WIDTH-1:0]   payload_q;
   logic [REFERENCE_WIDTH-1:0] index_q;
   logic                       collision_q, collision_d;
   logic                       accept;
   logic                       ctrl_hit;
   logic [7:0]                 cur_byte;

   function automatic logic is_ctrl(input logic [7:0] b);
      is_ctrl = (b == FRAME_HEADSTART) || (b == FRAME_START) || (b == FRAME_END);
   endfunction

   // Flag any incoming byte that aliases a control code; frames are not escaped.
   always_comb begin
      ctrl_hit = 1'b0;
      for (int i = 0; i < PAY_BYTES; i++) begin
         if (is_ctrl(payload_i[i*8 +: 8])) ctrl_hit = 1'b1;
      end
      for (int i = 0; i < REF_BYTES; i++) begin
         if (is_ctrl(index_i[i*8 +: 8])) ctrl_hit = 1'b1;
      end
   end

   // Select the byte on the wire, most-significant byte of each word first.
   always_comb begin
      cur_byte = 8'h00;
      case (state_q)
         StHeadstart: cur_byte = FRAME_HEADSTART;
         StIndex: begin
            for (int j = 0; j < REF_BYTES; j++) begin
               if (byte_cnt_q == BYTE_W'(j)) cur_byte = index_q[(REF_BYTES-1-j)*8 +: 8];
            end
         end
         StStart: cur_byte = FRAME_START;
         StData: begin
            for (int j = 0; j < PAY_BYTES; j++) begin
               if (byte_cnt_q == BYTE_W'(j)) cur_byte = payload_q[(PAY_BYTES-1-j)*8 +: 8];
            end
         end
         StEnd:   cur_byte = FRAME_END;
         default: cur_byte = 8'h00;
      endcase
   end

   // Next-state, counter sequencing and frame-completion pulse.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      byte_cnt_d  = byte_cnt_q;
      accept      = 1'b0;
      done        = 1'b0;
      collision_d = 1'b0;
      if (state_q == StIdle) begin
         if (load) begin
            accept      = 1'b1;
            collision_d = ctrl_hit;
            state_d     = StHeadstart;
            bit_cnt_d   = '0;
            bit_idx_d   = '0;
            byte_cnt_d  = '0;
         end
      end else begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
         if (bit_cnt_q == BIT_LAST) begin
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               case (state_q)
                  StHeadstart: begin
                     state_d    = StIndex;
                     byte_cnt_d = '0;
                  end
                  StIndex: begin
                     if (byte_cnt_q == REF_LAST) begin
                        state_d    = StStart;
                        byte_cnt_d = '0;
                     end
                  end
                  StStart: begin
                     state_d    = StData;
                     byte_cnt_d = '0;
                  end
                  StData: begin
                     if (byte_cnt_q == PAY_LAST) begin
                        state_d    = StEnd;
                        byte_cnt_d = '0;
                     end
                  end
                  StEnd: begin
                     state_d    = StIdle;
                     byte_cnt_d = '0;
                     done       = 1'b1;
                  end
                  default: begin
                     state_d    = StIdle;
                     byte_cnt_d = '0;
                  end
               endcase
            end
         end
      end
   end

   // State, counters and captured words; reset aborts a frame immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         byte_cnt_q  <= '0;
         payload_q   <= '0;
         index_q     <= '0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         collision_q <= collision_d;
         if (accept) begin
            payload_q <= payload_i;
            index_q   <= index_i;
         end
      end
   end

   assign ready       = (state_q == StIdle);
   assign write       = !ready && (bit_cnt_q >= BIT_HALF);
   assign data_stream = !ready && cur_byte[3'd7 - bit_idx_q];
   assign collision   = collision_q;

endmodule

// File: tb/tb_transmitter_framer.sv
// Self-checking bench for transmitter_framer: a strobe-driven receiver model
// collects bytes into a queue that is checked against the expected frame queue.
module tb_transmitter_framer;

   localparam int BP        = 4;
   localparam int PW        = 16;
   localparam int RW        = 16;
   localparam int NBYTES    = 3 + PW/8 + RW/8;
   localparam int FRAME_CYC = 8 * NBYTES * BP;
   localparam logic [7:0] HS = 8'hA5;
   localparam logic [7:0] ST = 8'h5A;
   localparam logic [7:0] EN = 8'h7E;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic [PW-1:0] payload_i = '0;
   logic [RW-1:0] index_i = '0;
   logic          ready, data_stream, write, done, collision;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] frame_bytes[NBYTES];
   int         n_strobes;
   int         rx_bits;
   logic [7:0] rx_sr;
   logic       write_prev;

   always #5 clk = ~clk;

   transmitter_framer #(
      .PAYLOAD_WIDTH   (PW),
      .REFERENCE_WIDTH (RW),
      .BIT_PERIOD      (BP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .payload_i   (payload_i),
      .index_i     (index_i),
      .ready       (ready),
      .data_stream (data_stream),
      .write       (write),
      .done        (done),
      .collision   (collision)
   );

   // Receiver model: shift data_stream in on each write rising edge.
   initial begin
      rx_bits = 0; write_prev = 1'b0; n_strobes = 0; rx_sr = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            rx_bits = 0; write_prev = 1'b0;
         end else begin
            if (write && !write_prev) begin
               rx_sr = {rx_sr[6:0], data_stream};
               rx_bits++; n_strobes++;
               if (rx_bits == 8) begin rx_q.push_back(rx_sr); rx_bits = 0; end
            end
            write_prev = write;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   // Build the expected frame and push it to the scoreboard.
   task automatic launch(input logic [RW-1:0] idx, input logic [PW-1:0] pay);
      frame_bytes[0] = HS;
      for (int i = 0; i < RW/8; i++) frame_bytes[1+i] = idx[RW-1-8*i -: 8];
      frame_bytes[1+RW/8] = ST;
      for (int i = 0; i < PW/8; i++) frame_bytes[2+RW/8+i] = pay[PW-1-8*i -: 8];
      frame_bytes[NBYTES-1] = EN;
      for (int i = 0; i < NBYTES; i++) exp_q.push_back(frame_bytes[i]);
   endtask

   // Present a frame in the idle cycle; returns #1 after the accepting edge.
   task automatic accept_frame(input logic [RW-1:0] idx, input logic [PW-1:0] pay,
                               input bit hold);
      @(negedge clk);
      load = 1'b1; index_i = idx; payload_i = pay;
      @(posedge clk);
      launch(idx, pay);
      #1;
      if (!hold) load = 1'b0;
   endtask

   // Follow a frame cycle by cycle, counting deviations from the bit-level model.
   task automatic run_frame(input int pulse_at, input int stop_at,
                            output int done_cyc, output int bad);
      logic [7:0] b;
      logic       exp_w, exp_d;
      done_cyc = -1; bad = 0;
      for (int k = 0; k < FRAME_CYC + 20; k++) begin
         @(negedge clk);
         if (k < FRAME_CYC) begin
            b     = frame_bytes[k/(8*BP)];
            exp_w = (k % BP) >= BP/2;
            exp_d = b[7-((k/BP)%8)];
            if (write !== exp_w || data_stream !== exp_d || ready !== 1'b0) bad++;
            if (done !== (k == FRAME_CYC-1)) bad++;
            if (k > 0 && collision !== 1'b0) bad++;
         end
         if (pulse_at >= 0 && k == pulse_at) begin
            load = 1'b1; payload_i = '1; index_i = '0;
         end else if (pulse_at >= 0 && k == pulse_at + 1) begin
            load = 1'b0;
         end
         if (k == stop_at) return;
         if (done === 1'b1) begin done_cyc = k; return; end
      end
   endtask

   // Pop expected against received bytes; counts mismatches and leftovers.
   task automatic drain(output int bad, output int nrx);
      logic [7:0] e, a;
      bad = 0; nrx = rx_q.size();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 8'hxx;
         if (a !== e) bad++;
      end
      bad += rx_q.size();
      rx_q.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
      n_vec++; if (data_stream !== 1'b0) begin n_err++; $display("FAIL reset_data: got %b expected 0", data_stream); end
      n_vec++; if (write !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b expected 0", write); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
      n_vec++; if (collision !== 1'b0) begin n_err++; $display("FAIL reset_collision: got %b expected 0", collision); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int dc, bad, nrx;
      n_strobes = 0;
      accept_frame(16'h1234, 16'hABCD, 1'b0);
      n_vec++; if (collision !== 1'b0) begin n_err++; $display("FAIL basic_collision: got %b expected 0", collision); end
      run_frame(-1, -1, dc, bad);
      n_vec++; if (dc !== FRAME_CYC-1) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected %0d", dc, FRAME_CYC-1); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL basic_bitstream: got %0d bad cycles expected 0", bad); end
      @(negedge clk);
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after: got %b expected 1", ready); end
      n_vec++; if (n_strobes !== 8*NBYTES) begin n_err++; $display("FAIL basic_strobes: got %0d expected %0d", n_strobes, 8*NBYTES); end
      drain(bad, nrx);
      n_vec++; if (nrx !== NBYTES) begin n_err++; $display("FAIL basic_rx_count: got %0d expected %0d", nrx, NBYTES); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL basic_bytes: got %0d bad bytes expected 0", bad); end
   endtask

   task automatic test_loopback();
      int dc, bad;
      logic [RW-1:0] idx_w;
      logic [PW-1:0] pay_w;
      logic          send;
      accept_frame(16'h1234, 16'hABCD, 1'b0);
      run_frame(-1, -1, dc, bad);
      @(negedge clk);
      send = (rx_q.size() == NBYTES) && (rx_q[0] == HS) && (rx_q[1+RW/8] == ST)
             && (rx_q[NBYTES-1] == EN);
      idx_w = '0; pay_w = '0;
      for (int i = 0; i < RW/8; i++) idx_w = {idx_w[RW-9:0], rx_q[1+i]};
      for (int i = 0; i < PW/8; i++) pay_w = {pay_w[PW-9:0], rx_q[2+RW/8+i]};
      n_vec++; if (send !== 1'b1) begin n_err++; $display("FAIL loop_send: got %b expected 1", send); end
      n_vec++; if (idx_w !== 16'h1234) begin n_err++; $display("FAIL loop_index: got %h expected 1234", idx_w); end
      n_vec++; if (pay_w !== 16'hABCD) begin n_err++; $display("FAIL loop_payload: got %h expected abcd", pay_w); end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_busy_ignore();
      int dc, bad, nrx;
      accept_frame(16'h1234, 16'hABCD, 1'b0);
      run_frame(50, -1, dc, bad);
      n_vec++; if (dc !== FRAME_CYC-1) begin n_err++; $display("FAIL busy_done_cycle: got %0d expected %0d", dc, FRAME_CYC-1); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL busy_bitstream: got %0d bad cycles expected 0", bad); end
      @(negedge clk);
      drain(bad, nrx);
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL busy_bytes: got %0d bad bytes expected 0", bad); end
   endtask

   task automatic test_collision();
      int dc, bad, nrx;
      accept_frame(16'h2233, {EN, 8'h11}, 1'b0);
      n_vec++; if (collision !== 1'b1) begin n_err++; $display("FAIL coll_pulse: got %b expected 1", collision); end
      run_frame(-1, -1, dc, bad);
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL coll_bitstream: got %0d bad cycles expected 0", bad); end
      n_vec++; if (dc !== FRAME_CYC-1) begin n_err++; $display("FAIL coll_done_cycle: got %0d expected %0d", dc, FRAME_CYC-1); end
      @(negedge clk);
      drain(bad, nrx);
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL coll_bytes: got %0d bad bytes expected 0", bad); end
   endtask

   task automatic test_back_to_back();
      int dc, bad, nrx;
      n_strobes = 0;
      accept_frame(16'h5566, 16'h7788, 1'b1);
      run_frame(-1, -1, dc, bad);
      n_vec++; if (dc !== FRAME_CYC-1 || bad !== 0) begin n_err++; $display("FAIL b2b_frame1: got done %0d bad %0d expected done %0d bad 0", dc, bad, FRAME_CYC-1); end
      @(negedge clk);
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_gap: got ready %b expected 1", ready); end
      @(posedge clk);
      launch(16'h5566, 16'h7788);
      #1;
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept: got ready %b expected 0", ready); end
      run_frame(-1, -1, dc, bad);
      load = 1'b0;
      n_vec++; if (dc !== FRAME_CYC-1) begin n_err++; $display("FAIL b2b_done2: got %0d expected %0d", dc, FRAME_CYC-1); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_strobe_duty: got %0d bad cycles expected 0", bad); end
      repeat (2) @(negedge clk);
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_no_third: got ready %b expected 1", ready); end
      n_vec++; if (n_strobes !== 16*NBYTES) begin n_err++; $display("FAIL b2b_strobes: got %0d expected %0d", n_strobes, 16*NBYTES); end
      drain(bad, nrx);
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_bytes: got %0d bad bytes expected 0", bad); end
   endtask

   task automatic test_mid_reset();
      int dc, bad, nrx, done_seen;
      accept_frame(16'h1234, 16'hABCD, 1'b0);
      // Stop mid-strobe so the abort has a high write and data bit to clear.
      run_frame(-1, 102, dc, bad);
      n_vec++; if (write !== 1'b1 || data_stream !== 1'b1) begin n_err++; $display("FAIL mrst_pre: got write %b data %b expected 1 1", write, data_stream); end
      #1 rst = 1'b1;
      #1;
      n_vec++; if (write !== 1'b0) begin n_err++; $display("FAIL mrst_write: got %b expected 0", write); end
      n_vec++; if (data_stream !== 1'b0) begin n_err++; $display("FAIL mrst_data: got %b expected 0", data_stream); end
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b expected 1", ready); end
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) done_seen++;
      end
      n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL mrst_no_done: got %0d done cycles expected 0", done_seen); end
      rst = 1'b0;
      exp_q.delete(); rx_q.delete();
      load = 1'b1; index_i = 16'hC3D2; payload_i = 16'h0102;
      @(posedge clk);
      launch(16'hC3D2, 16'h0102);
      #1 load = 1'b0;
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL mrst_first_edge: got ready %b expected 0", ready); end
      run_frame(-1, -1, dc, bad);
      n_vec++; if (dc !== FRAME_CYC-1 || bad !== 0) begin n_err++; $display("FAIL mrst_frame: got done %0d bad %0d expected done %0d bad 0", dc, bad, FRAME_CYC-1); end
      @(negedge clk);
      drain(bad, nrx);
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mrst_bytes: got %0d bad bytes expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loopback();
      test_busy_ignore();
      test_collision();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
